// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs an external 4-bit ALU as a WIDTH-bit ALU, one nibble per clock.
// Optional: ALU_NIBBLE_SEQ_BACK2BACK_EN lets a start in DONE launch the next op at once.
module alu_nibble_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             sign,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_r,
  input  logic             alu_carry
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [2:0]       op_q;
  logic             carry_reg;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             carry_q;
  logic             sign_q;

  logic             accept;
  logic             last;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [WIDTH-1:0] res_next;

`ifdef ALU_NIBBLE_SEQ_BACK2BACK_EN
  assign accept = start && (state == S_IDLE || state == S_DONE);
`else
  assign accept = start && (state == S_IDLE);
`endif

  assign last = (idx == IW'(N - 1));

  // Select the active operand nibbles and merge the ALU output into the result
  always_comb begin
    a_nib    = 4'd0;
    b_nib    = 4'd0;
    res_next = result_q;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
        res_next[4*i +: 4] = alu_r;
      end
    end
  end

  // ALU drive: idle lines parked at zero, op held stable from the last capture
  always_comb begin
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_cin = 1'b0;
    alu_op  = op_q;
    if (state == S_RUN) begin
      alu_a = a_nib;
      alu_b = b_nib;
      if (idx == '0) alu_cin = cin_q;
      else           alu_cin = op_q[2] ? 1'b0 : carry_reg;
    end
  end

  // Sequencer: capture, step through nibbles, assemble result and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      op_q      <= 3'd0;
      carry_reg <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      carry_q   <= 1'b0;
      sign_q    <= 1'b0;
    end else if (accept) begin
      state     <= S_RUN;
      idx       <= '0;
      a_q       <= a;
      b_q       <= b;
      cin_q     <= c_in;
      op_q      <= op;
      carry_reg <= 1'b0;
    end else if (state == S_RUN) begin
      result_q  <= res_next;
      carry_reg <= alu_carry;
      idx       <= idx + 1'b1;
      if (last) begin
        state   <= S_DONE;
        zero_q  <= (res_next == '0);
        sign_q  <= res_next[WIDTH-1];
        carry_q <= op_q[2] ? 1'b0 : alu_carry;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign sign   = sign_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb_alu_nibble_seq: vector table, random ops vs. full-width model,
// plus reset-abort and start-during-RUN/DONE sequences.
module tb_alu_nibble_seq;

  localparam int W = 8;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic [2:0]   op;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         sign;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [2:0]   alu_op;
  logic [3:0]   alu_r;
  logic         alu_carry;

  int checks = 0;
  int errors = 0;
  logic cin_log [8];

  alu_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .c_in(c_in), .op(op),
    .busy(busy), .done(done), .result(result),
    .zero(zero), .carry(carry), .sign(sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_r(alu_r), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  // 4-bit ALU: add, sub, inc, dec; and, or, xor, not (logic carry is junk 1)
  logic [4:0] s5;
  always_comb begin
    s5        = 5'd0;
    alu_r     = 4'd0;
    alu_carry = 1'b0;
    case (alu_op[1:0])
      2'b00: s5 = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
      2'b01: s5 = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_cin);
      2'b10: s5 = {1'b0, alu_a} + 5'(alu_cin);
      default: s5 = {1'b0, alu_a} + 5'h0F + 5'(alu_cin);
    endcase
    if (!alu_op[2]) begin
      {alu_carry, alu_r} = s5;
    end else begin
      alu_carry = 1'b1;
      case (alu_op[1:0])
        2'b00: alu_r = alu_a & alu_b;
        2'b01: alu_r = alu_a | alu_b;
        2'b10: alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
    end
  end

  function automatic logic [W:0] ref_alu(input logic [W-1:0] x, y,
                                         input logic ci, input logic [2:0] o);
    logic [W:0] full;
    logic [W-1:0] ones;
    ones = '1;
    full = '0;
    case (o)
      3'b000: full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      3'b001: full = {1'b0, x} + {1'b0, ~y} + (W+1)'(ci);
      3'b010: full = {1'b0, x} + (W+1)'(ci);
      3'b011: full = {1'b0, x} + {1'b0, ones} + (W+1)'(ci);
      3'b100: full = {1'b0, x & y};
      3'b101: full = {1'b0, x | y};
      3'b110: full = {1'b0, x ^ y};
      default: full = {1'b0, ~x};
    endcase
    return full;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_zero"}, 64'(zero), 64'd1);
    chk({tag, "_carry"}, 64'(carry), 64'd0);
    chk({tag, "_sign"}, 64'(sign), 64'd0);
    chk({tag, "_alu_drv"}, 64'({alu_a, alu_b, alu_cin, alu_op}), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, tb_, input logic tc,
                        input logic [2:0] to, input bit scramble,
                        output logic [W-1:0] r, output logic cy, z, s,
                        output int lat, output int bn);
    bit got;
    @(negedge clk);
    a = ta; b = tb_; c_in = tc; op = to; start = 1'b1;
    @(posedge clk);
    lat = 0; bn = 0; got = 0;
    r = '0; cy = 0; z = 0; s = 0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) begin
        if (bn < 8) cin_log[bn] = alu_cin;
        bn++;
      end
      if (scramble) begin
        a = W'($urandom); b = W'($urandom);
        c_in = 1'($urandom); op = 3'($urandom);
      end
      if (done) begin
        lat = k; r = result; cy = carry; z = zero; s = sign;
        got = 1;
        break;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
  endtask

  typedef struct {
    logic [W-1:0] va, vb;
    logic         vc;
    logic [2:0]   vop;
    logic [W-1:0] er;
    logic         ecy, ez, es;
  } vec_t;

  vec_t vt [6];

  logic [W-1:0] r;
  logic cy, z, s;
  int lat, bn;
  logic [W:0] exp_full;

  initial begin
    vt[0] = '{8'h3A, 8'h29, 1'b0, 3'b000, 8'h63, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h00, 1'b1, 3'b000, 8'h80, 1'b0, 1'b0, 1'b1};
    vt[3] = '{8'hF0, 8'h0F, 1'b1, 3'b110, 8'hFF, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'h10, 8'h01, 1'b1, 3'b001, 8'h0F, 1'b1, 1'b0, 1'b0};
    vt[5] = '{8'hF0, 8'h0F, 1'b0, 3'b100, 8'h00, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b1;
    a = 8'h55; b = 8'h66; c_in = 1'b1; op = 3'b000;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_override_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].va, vt[i].vb, vt[i].vc, vt[i].vop, 1'b0,
             r, cy, z, s, lat, bn);
      chk($sformatf("v%0d_result", i), 64'(r), 64'(vt[i].er));
      chk($sformatf("v%0d_carry", i), 64'(cy), 64'(vt[i].ecy));
      chk($sformatf("v%0d_zero", i), 64'(z), 64'(vt[i].ez));
      chk($sformatf("v%0d_sign", i), 64'(s), 64'(vt[i].es));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(N + 1));
      chk($sformatf("v%0d_busy_cycles", i), 64'(bn), 64'(N));
      if (i == 1) chk("v1_cin_idx1", 64'(cin_log[1]), 64'd1);
      if (i == 3) begin
        chk("v3_cin_idx0", 64'(cin_log[0]), 64'd1);
        chk("v3_cin_idx1", 64'(cin_log[1]), 64'd0);
      end
    end

    repeat (40) begin
      logic [W-1:0] ra, rb;
      logic rc;
      logic [2:0] ro;
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); ro = 3'($urandom);
      exp_full = ref_alu(ra, rb, rc, ro);
      run_op(ra, rb, rc, ro, 1'b1, r, cy, z, s, lat, bn);
      chk("rnd_result", 64'(r), 64'(exp_full[W-1:0]));
      chk("rnd_carry", 64'(cy), 64'(exp_full[W]));
      chk("rnd_zero", 64'(z), 64'(exp_full[W-1:0] == '0));
      chk("rnd_sign", 64'(s), 64'(exp_full[W-1]));
      chk("rnd_latency", 64'(lat), 64'(N + 1));
    end

    begin
      int dcount;
      dcount = 0;
      @(negedge clk);
      a = 8'hAB; b = 8'hCD; c_in = 1'b1; op = 3'b000; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("abort");
      if (done) dcount++;
      reset = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (done) dcount++;
      end
      chk("abort_no_done", 64'(dcount), 64'd0);
      run_op(8'h11, 8'h22, 1'b0, 3'b000, 1'b0, r, cy, z, s, lat, bn);
      chk("post_abort_result", 64'(r), 64'h33);
      chk("post_abort_latency", 64'(lat), 64'(N + 1));
    end

    begin
      int d1, d2;
      logic busy_after;
      logic [W-1:0] r1, r2;
      d1 = 0; d2 = 0; busy_after = 1'bx; r1 = '0; r2 = '0;
      @(negedge clk);
      a = 8'h12; b = 8'h34; c_in = 1'b0; op = 3'b000; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (k == 1) begin
          a = 8'hEE; b = 8'hEE;
        end
        if (k == N + 2) busy_after = busy;
        if (done && d1 == 0) begin
          d1 = k; r1 = result;
          a = 8'h05; b = 8'h06;
        end else if (done && d2 == 0) begin
          d2 = k; r2 = result;
          start = 1'b0;
          break;
        end
      end
      start = 1'b0;
      chk("hold_first_latency", 64'(d1), 64'(N + 1));
      chk("hold_first_result", 64'(r1), 64'h46);
      chk("hold_second_result", 64'(r2), 64'h0B);
`ifdef ALU_NIBBLE_SEQ_BACK2BACK_EN
      chk("b2b_busy_after_done", 64'(busy_after), 64'd1);
      chk("b2b_second_done", 64'(d2), 64'(2 * N + 2));
`else
      chk("idle_after_done", 64'(busy_after), 64'd0);
      chk("second_done", 64'(d2), 64'(2 * N + 3));
`endif
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle controller that runs the 4-bit ALU as a WIDTH-bit ALU, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles for arithmetic ops. The wide result and flags are assembled in registers.
- Sits between a requester (start/done handshake) and a single external `alu` instance. This block drives the ALU's A, B, c_in and Op inputs and samples its R and carry outputs.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibble steps.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only when accepting (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry into the least-significant nibble
- op  in  3  ALU opcode: op[2]=0 selects the adder path, op[2]=1 selects the logic unit
- busy  out  1  high while nibble steps run
- done  out  1  one-cycle pulse when the result is valid
- result  out  WIDTH  assembled result
- zero  out  1  result == 0
- carry  out  1  final carry (arithmetic only)
- sign  out  1  result[WIDTH-1]
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_cin  out  1  to ALU c_in
- alu_op  out  3  to ALU Op
- alu_r  in  4  from ALU R
- alu_carry  in  1  from ALU carry

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 captures a, b, c_in and op into internal registers, clears idx to 0, and moves to RUN. start=0 stays in IDLE.
  - RUN: once per cycle, drive captured nibble idx onto alu_a/alu_b and captured op onto alu_op.
  - RUN, at each rising edge: result[4*idx+3:4*idx] <= alu_r; carry_reg <= alu_carry; idx <= idx+1.
  - RUN exits after idx = N-1 to DONE. There is no early exit.
  - DONE: done=1 for exactly this one cycle, then return to IDLE.
- alu_cin rules:
  - idx=0: the captured c_in.
  - idx>0 with op[2]=0: carry_reg from the previous nibble.
  - idx>0 with op[2]=1: 0.
- ALU drive outside RUN: alu_a=alu_b=0, alu_cin=0, alu_op=captured op (kept stable).
- The ALU is combinational. Each nibble sees a one-cycle combinational path from registers through the ALU back to registers.
- Latency:
  - start sampled at edge E0.
  - busy high for cycles E0+1 … E0+N.
  - done high in cycle E0+N+1.
  - Throughput is one op per N+2 cycles (see the optional feature).
- Flags:
  - Registered. They update on the edge entering DONE and hold until the next accepted start.
  - zero = (assembled result == 0). It is computed over the full WIDTH, not per nibble.
  - sign = result MSB.
  - carry = carry_reg after the last nibble when op[2]=0. It is forced to 0 when op[2]=1.
- result:
  - Nibbles are written progressively during RUN.
  - Valid only when done=1. It holds its value until the next accepted start.
- Input stability:
  - a, b, c_in and op are only sampled at acceptance.
  - Changes during RUN/DONE have no effect.
  - start during RUN is ignored (no queuing).
- Reset:
  - Forces state IDLE, idx=0, busy=0, done=0, result=0, zero=1, carry=0, sign=0, and ALU drive lines to 0.
  - It overrides start in the same cycle.
  - Reset mid-RUN abandons the op with no done pulse.

Optional Feature:
- Macro: ALU_NIBBLE_SEQ_BACK2BACK_EN
- Defined: start=1 in DONE is accepted, recaptures the operands, and goes directly to RUN with idx=0. done still pulses for the finishing op. Throughput becomes one op per N+1 cycles.
- Undefined: start in DONE is ignored; the requester must reassert it in IDLE.

Test Plan:
1. WIDTH=8, op=3'b000, a=0x3A, b=0x29, c_in=0 -> done exactly 3 cycles after the start edge; result=0x63, carry=0, zero=0, sign=0; busy high for exactly 2 cycles.
2. op=3'b000, a=0xFF, b=0x01, c_in=0 -> result=0x00, carry=1, zero=1, sign=0. Check that the inter-nibble carry propagates (alu_cin=1 on idx=1).
3. op=3'b000, a=0x7F, b=0x00, c_in=1 -> result=0x80, sign=1, carry=0.
4. Logic op (op[2]=1), a=0xF0, b=0x0F, c_in=1 -> alu_cin=1 on idx 0 and 0 on idx 1. result = {ALU(0xF,0x0), ALU(0x0,0xF)} per the single-cycle ALU. carry=0.
5. Assert reset in the second RUN cycle, then start a new op (0x11+0x22, op=3'b000) -> no done for the aborted op; all outputs at reset values; the new op gives result=0x33 with the normal latency.
6. Pulse start during RUN and hold it in DONE -> ignored without the macro (next acceptance only in IDLE). With ALU_NIBBLE_SEQ_BACK2BACK_EN, the second op starts the cycle after done, with no IDLE cycle in between.
